reg_n_toggle_mon: RTL and testbench

Parametrised WIDTH-bit register with async active-low clear, a run-time mode select (hold / parallel load / shift-left / sync clear), and a built-in switching-activity monitor. Each clock it counts the output bits that changed and accumulates them into a saturating counter. Board-level power estimation scales that count by load capacitance and Vcc². It replaces single-bit D flip-flops wherever a data register plus dynamic-power accounting is needed.

---
 rtl/reg_n_toggle_mon.sv | 106 ++++++++++
 tb/tb_reg_n_toggle_mon.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_n_toggle_mon.sv
// WIDTH-bit mode register with a saturating count of output bit toggles.
// Q, TOG_CNT, TOG_SAT and Q_CHG share one clock edge and one async clear.
module reg_n_toggle_mon #(
   parameter int               WIDTH     = 8,
   parameter int               CNT_W     = 16,
   parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
   input  logic             CLK,
   input  logic             CLR_BAR,
   input  logic [1:0]       MODE,
   input  logic [WIDTH-1:0] D,
   input  logic             SIN,
   input  logic             CNT_CLR,
   output logic [WIDTH-1:0] Q,
   output logic             SOUT,
   output logic [CNT_W-1:0] TOG_CNT,
   output logic             TOG_SAT,
   output logic             Q_CHG
);

   localparam int TW = $clog2(WIDTH + 1);

   localparam logic [1:0] M_HOLD  = 2'b00;
   localparam logic [1:0] M_LOAD  = 2'b01;
   localparam logic [1:0] M_SHIFT = 2'b10;
   localparam logic [1:0] M_CLR   = 2'b11;

   logic [WIDTH-1:0] q_q, q_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sat_q, sat_d;
   logic             chg_q, chg_d;

   logic [WIDTH-1:0] shift_val;
   logic [WIDTH-1:0] diff;
   logic [TW-1:0]    tog;
   logic [CNT_W:0]   sum;

   // Shift-left value; a 1-bit register simply takes SIN.
   generate
      if (WIDTH == 1) begin : g_shift1
         assign shift_val = SIN;
      end else begin : g_shiftn
         assign shift_val = {q_q[WIDTH-2:0], SIN};
      end
   endgenerate

   // Next register value selected by MODE.
   always_comb begin
      q_d = q_q;
      unique case (MODE)
         M_HOLD:  q_d = q_q;
         M_LOAD:  q_d = D;
         M_SHIFT: q_d = shift_val;
         M_CLR:   q_d = RESET_VAL;
         default: q_d = q_q;
      endcase
   end

   // Count bits that change on this edge.
   always_comb begin
      diff = q_d ^ q_q;
      tog  = '0;
      for (int i = 0; i < WIDTH; i++) begin
         tog = tog + TW'(diff[i]);
      end
   end

   // Widened add, then clamp; a counter clear restarts from this edge's toggles.
   always_comb begin
      sum   = {1'b0, cnt_q} + (CNT_W + 1)'(tog);
      cnt_d = cnt_q;
      sat_d = sat_q;
      chg_d = (tog != '0);
      if (CNT_CLR) begin
         cnt_d = CNT_W'(tog);
         sat_d = 1'b0;
      end else if (sum[CNT_W]) begin
         cnt_d = {CNT_W{1'b1}};
         sat_d = 1'b1;
      end else begin
         cnt_d = sum[CNT_W-1:0];
      end
   end

   // State registers with immediate clear to the reset value.
   always_ff @(posedge CLK or negedge CLR_BAR) begin
      if (!CLR_BAR) begin
         q_q   <= RESET_VAL;
         cnt_q <= '0;
         sat_q <= 1'b0;
         chg_q <= 1'b0;
      end else begin
         q_q   <= q_d;
         cnt_q <= cnt_d;
         sat_q <= sat_d;
         chg_q <= chg_d;
      end
   end

   assign Q       = q_q;
   assign SOUT    = q_q[WIDTH-1];
   assign TOG_CNT = cnt_q;
   assign TOG_SAT = sat_q;
   assign Q_CHG   = chg_q;

endmodule

// File: tb/tb_reg_n_toggle_mon.sv
// Directed bench: wide-counter instance a, 4-bit-counter instance b.
// Expected values are hand-computed per scenario.
module tb_reg_n_toggle_mon;

   logic        clk = 1'b0;
   logic        clr_bar = 1'b1;

   logic [1:0]  a_mode = 2'b00;
   logic [7:0]  a_d = 8'h00;
   logic        a_sin = 1'b0;
   logic        a_cclr = 1'b0;
   logic [7:0]  a_q;
   logic        a_sout;
   logic [15:0] a_cnt;
   logic        a_sat;
   logic        a_chg;

   logic [1:0]  b_mode = 2'b00;
   logic [7:0]  b_d = 8'h00;
   logic        b_sin = 1'b0;
   logic        b_cclr = 1'b0;
   logic [7:0]  b_q;
   logic        b_sout;
   logic [3:0]  b_cnt;
   logic        b_sat;
   logic        b_chg;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   reg_n_toggle_mon #(.WIDTH(8), .CNT_W(16), .RESET_VAL(8'h00)) u_a (
      .CLK(clk), .CLR_BAR(clr_bar), .MODE(a_mode), .D(a_d),
      .SIN(a_sin), .CNT_CLR(a_cclr), .Q(a_q), .SOUT(a_sout),
      .TOG_CNT(a_cnt), .TOG_SAT(a_sat), .Q_CHG(a_chg)
   );

   reg_n_toggle_mon #(.WIDTH(8), .CNT_W(4), .RESET_VAL(8'h3C)) u_b (
      .CLK(clk), .CLR_BAR(clr_bar), .MODE(b_mode), .D(b_d),
      .SIN(b_sin), .CNT_CLR(b_cclr), .Q(b_q), .SOUT(b_sout),
      .TOG_CNT(b_cnt), .TOG_SAT(b_sat), .Q_CHG(b_chg)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      @(posedge clk);
      #2;
      clr_bar = 1'b0;
      #1;
      checks++;
      if (a_q !== 8'h00 || a_cnt !== 16'd0 || a_chg !== 1'b0 || a_sat !== 1'b0) begin
         errors++;
         $display("FAIL reset_a q=%h cnt=%0d chg=%b sat=%b exp 00/0/0/0",
                  a_q, a_cnt, a_chg, a_sat);
      end
      checks++;
      if (b_q !== 8'h3C || b_cnt !== 4'd0 || b_sat !== 1'b0) begin
         errors++;
         $display("FAIL reset_b q=%h cnt=%0d sat=%b exp 3c/0/0", b_q, b_cnt, b_sat);
      end
      step();
      clr_bar = 1'b1;
   endtask

   task automatic test_load();
      a_mode = 2'b01; a_d = 8'hFF;
      step();
      checks++;
      if (a_q !== 8'hFF || a_cnt !== 16'd8 || a_chg !== 1'b1 || a_sout !== 1'b1) begin
         errors++;
         $display("FAIL load q=%h cnt=%0d chg=%b sout=%b exp ff/8/1/1",
                  a_q, a_cnt, a_chg, a_sout);
      end
      a_mode = 2'b00;
      step();
      checks++;
      if (a_q !== 8'hFF || a_cnt !== 16'd8 || a_chg !== 1'b0) begin
         errors++;
         $display("FAIL hold q=%h cnt=%0d chg=%b exp ff/8/0", a_q, a_cnt, a_chg);
      end
   endtask

   task automatic test_shift();
      a_mode = 2'b01; a_d = 8'h81;
      step();
      checks++;
      if (a_q !== 8'h81 || a_cnt !== 16'd14) begin
         errors++;
         $display("FAIL preload81 q=%h cnt=%0d exp 81/14", a_q, a_cnt);
      end
      a_mode = 2'b10; a_sin = 1'b1;
      step();
      checks++;
      if (a_q !== 8'h03 || a_cnt !== 16'd16 || a_sout !== 1'b0 || a_chg !== 1'b1) begin
         errors++;
         $display("FAIL shift1 q=%h cnt=%0d sout=%b chg=%b exp 03/16/0/1",
                  a_q, a_cnt, a_sout, a_chg);
      end
      a_sin = 1'b0;
      step();
      checks++;
      if (a_q !== 8'h06 || a_cnt !== 16'd18) begin
         errors++;
         $display("FAIL shift2 q=%h cnt=%0d exp 06/18", a_q, a_cnt);
      end
   endtask

   task automatic test_sync_clear();
      a_mode = 2'b01; a_d = 8'h5A;
      step();
      checks++;
      if (a_q !== 8'h5A || a_cnt !== 16'd22) begin
         errors++;
         $display("FAIL preload5a q=%h cnt=%0d exp 5a/22", a_q, a_cnt);
      end
      a_mode = 2'b11;
      step();
      checks++;
      if (a_q !== 8'h00 || a_cnt !== 16'd26 || a_chg !== 1'b1) begin
         errors++;
         $display("FAIL sync_clr q=%h cnt=%0d chg=%b exp 00/26/1", a_q, a_cnt, a_chg);
      end
   endtask

   task automatic test_saturation();
      b_mode = 2'b01; b_d = 8'h00;
      step();
      checks++;
      if (b_q !== 8'h00 || b_cnt !== 4'd4) begin
         errors++;
         $display("FAIL sat_pre q=%h cnt=%0d exp 00/4", b_q, b_cnt);
      end
      b_mode = 2'b00; b_cclr = 1'b1;
      step();
      checks++;
      if (b_cnt !== 4'd0 || b_sat !== 1'b0 || b_chg !== 1'b0) begin
         errors++;
         $display("FAIL cclr_idle cnt=%0d sat=%b chg=%b exp 0/0/0", b_cnt, b_sat, b_chg);
      end
      b_cclr = 1'b0; b_mode = 2'b01; b_d = 8'hFF;
      step();
      checks++;
      if (b_cnt !== 4'd8 || b_sat !== 1'b0) begin
         errors++;
         $display("FAIL sat_e1 cnt=%0d sat=%b exp 8/0", b_cnt, b_sat);
      end
      b_d = 8'h00;
      step();
      checks++;
      if (b_cnt !== 4'd15 || b_sat !== 1'b1) begin
         errors++;
         $display("FAIL sat_e2 cnt=%0d sat=%b exp 15/1", b_cnt, b_sat);
      end
      b_d = 8'hFF;
      step();
      checks++;
      if (b_cnt !== 4'd15 || b_sat !== 1'b1 || b_q !== 8'hFF) begin
         errors++;
         $display("FAIL sat_e3 cnt=%0d sat=%b q=%h exp 15/1/ff", b_cnt, b_sat, b_q);
      end
   endtask

   task automatic test_cnt_clr();
      b_mode = 2'b01; b_d = 8'hF8; b_cclr = 1'b1;
      step();
      checks++;
      if (b_cnt !== 4'd3 || b_sat !== 1'b0 || b_q !== 8'hF8) begin
         errors++;
         $display("FAIL cnt_clr cnt=%0d sat=%b q=%h exp 3/0/f8", b_cnt, b_sat, b_q);
      end
      b_cclr = 1'b0; b_mode = 2'b00;
   endtask

   task automatic test_reset_mid();
      a_mode = 2'b01; a_d = 8'hAA; a_cclr = 1'b1;
      step();
      a_cclr = 1'b0; a_d = 8'h55;
      step();
      a_d = 8'hAA;
      step();
      checks++;
      if (a_q !== 8'hAA || a_cnt !== 16'd20) begin
         errors++;
         $display("FAIL pre_rst q=%h cnt=%0d exp aa/20", a_q, a_cnt);
      end
      #2;
      clr_bar = 1'b0;
      #1;
      checks++;
      if (a_q !== 8'h00 || a_cnt !== 16'd0 || a_chg !== 1'b0) begin
         errors++;
         $display("FAIL mid_rst q=%h cnt=%0d chg=%b exp 00/0/0", a_q, a_cnt, a_chg);
      end
      a_d = 8'hFF;
      step();
      step();
      checks++;
      if (a_q !== 8'h00 || a_cnt !== 16'd0 || b_q !== 8'h3C || b_cnt !== 4'd0) begin
         errors++;
         $display("FAIL rst_hold aq=%h acnt=%0d bq=%h bcnt=%0d exp 00/0/3c/0",
                  a_q, a_cnt, b_q, b_cnt);
      end
      clr_bar = 1'b1;
      step();
      checks++;
      if (a_q !== 8'hFF || a_cnt !== 16'd8 || a_chg !== 1'b1) begin
         errors++;
         $display("FAIL post_rst q=%h cnt=%0d chg=%b exp ff/8/1", a_q, a_cnt, a_chg);
      end
   endtask

   initial begin
      test_reset();
      test_load();
      test_shift();
      test_sync_clear();
      test_saturation();
      test_cnt_clr();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
